// File: rtl/uart_cmd_decoder_if.sv
// UART byte-stream handshake between the receiver/transmitter and the command decoder.
interface uart_cmd_decoder_if;
   logic [7:0] rx_data;
   logic       new_rx_data;
   logic [7:0] tx_data_o;
   logic       tx_start_o;
   logic       tx_ready_i;

   // UART side: supplies received bytes and transmitter status, consumes tx requests
   modport master (
      output rx_data,
      output new_rx_data,
      output tx_ready_i,
      input  tx_data_o,
      input  tx_start_o
   );

   // Decoder side
   modport slave (
      input  rx_data,
      input  new_rx_data,
      input  tx_ready_i,
      output tx_data_o,
      output tx_start_o
   );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Host command line decoder: parses <cmd>[hh]<EOL> lines from the UART and drives
// CSoC test-control pins, then acknowledges each line with "K\n" or "?\n".
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for the command byte
// ARG_HI    | waiting for high hex digit of argument
// ARG_LO    | waiting for low hex digit of argument
// WAIT_EOL  | command complete, waiting for line terminator
// DISCARD   | bad line, dropping bytes until line terminator
// EXEC      | one cycle: apply command to csoc outputs
// PULSE_HI  | csoc_clk high phase
// PULSE_LO  | csoc_clk low phase
// RESP      | waiting for tx ready, then launching a response byte
// RESP_WAIT | waiting for transmitter to drop ready (byte accepted)
module uart_cmd_decoder #(
   parameter int unsigned CLK_HALF = 4,
   parameter logic [7:0]  EOL      = 8'h0A
) (
   input  logic              clk,
   input  logic              rstn,
   uart_cmd_decoder_if.slave uart,
   output logic              csoc_clk,
   output logic              csoc_rstn,
   output logic              csoc_test_se,
   output logic              csoc_test_tm,
   output logic              csoc_uart_read,
   output logic [7:0]        csoc_data_o,
   output logic              busy_o
);

   typedef enum logic [3:0] {
      IDLE, ARG_HI, ARG_LO, WAIT_EOL, DISCARD, EXEC, PULSE_HI, PULSE_LO, RESP, RESP_WAIT
   } state_t;

   localparam logic [7:0] HALF_RELOAD = 8'(CLK_HALF - 1);
   localparam logic [7:0] CR          = 8'h0D;

   state_t     state_q, state_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] arg_q, arg_d;
   logic       err_q, err_d;
   logic [8:0] cnt_q, cnt_d;
   logic [7:0] half_q, half_d;
   logic       byte_idx_q, byte_idx_d;
   logic       busy_q, busy_d;
   logic       csoc_clk_q, csoc_clk_d;
   logic       csoc_rstn_q, csoc_rstn_d;
   logic       se_q, se_d;
   logic       tm_q, tm_d;
   logic       read_q, read_d;
   logic [7:0] data_q, data_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_start_q, tx_start_d;

   logic       hex_ok;
   logic [3:0] hex_nib;
   logic       rx_byte;
   logic       rx_eol;

   // Hex digit decode of the incoming byte
   always_comb begin
      hex_ok  = 1'b1;
      hex_nib = 4'h0;
      if (uart.rx_data >= 8'h30 && uart.rx_data <= 8'h39) begin
         hex_nib = uart.rx_data[3:0];
      end else if ((uart.rx_data >= 8'h41 && uart.rx_data <= 8'h46) ||
                   (uart.rx_data >= 8'h61 && uart.rx_data <= 8'h66)) begin
         hex_nib = uart.rx_data[3:0] + 4'd9;
      end else begin
         hex_ok = 1'b0;
      end
   end

   // CR is invisible to the parser
   assign rx_byte = uart.new_rx_data && (uart.rx_data != CR);
   assign rx_eol  = uart.rx_data == EOL;

   // Next-state and output computation
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      arg_d       = arg_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      half_d      = half_q;
      byte_idx_d  = byte_idx_q;
      csoc_clk_d  = csoc_clk_q;
      csoc_rstn_d = csoc_rstn_q;
      se_d        = se_q;
      tm_d        = tm_q;
      read_d      = 1'b0;
      data_d      = data_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;

      case (state_q)
         IDLE: if (rx_byte) begin
            cmd_d = uart.rx_data;
            if (rx_eol) begin
               state_d = IDLE;
            end else begin
               case (uart.rx_data)
                  8'h43, 8'h57: state_d = ARG_HI;
                  8'h52, 8'h72, 8'h53, 8'h73, 8'h54, 8'h74: state_d = WAIT_EOL;
                  default: begin
                     err_d   = 1'b1;
                     state_d = DISCARD;
                  end
               endcase
            end
         end
         ARG_HI, ARG_LO: if (rx_byte) begin
            if (rx_eol) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else if (hex_ok) begin
               arg_d   = {arg_q[3:0], hex_nib};
               state_d = (state_q == ARG_HI) ? ARG_LO : WAIT_EOL;
            end else begin
               err_d   = 1'b1;
               state_d = DISCARD;
            end
         end
         WAIT_EOL: if (rx_byte) begin
            if (rx_eol) begin
               state_d = EXEC;
            end else begin
               err_d   = 1'b1;
               state_d = DISCARD;
            end
         end
         DISCARD: if (rx_byte && rx_eol) begin
            state_d = RESP;
         end
         EXEC: begin
            state_d = RESP;
            case (cmd_q)
               8'h52: csoc_rstn_d = 1'b0;
               8'h72: csoc_rstn_d = 1'b1;
               8'h53: se_d = 1'b1;
               8'h73: se_d = 1'b0;
               8'h54: tm_d = 1'b1;
               8'h74: tm_d = 1'b0;
               8'h57: begin
                  data_d = arg_q;
                  read_d = 1'b1;
               end
               8'h43: begin
                  cnt_d      = (arg_q == 8'h00) ? 9'd256 : {1'b0, arg_q};
                  half_d     = HALF_RELOAD;
                  csoc_clk_d = 1'b1;
                  state_d    = PULSE_HI;
               end
               default: ;
            endcase
         end
         PULSE_HI: begin
            if (half_q == 8'h00) begin
               csoc_clk_d = 1'b0;
               half_d     = HALF_RELOAD;
               state_d    = PULSE_LO;
            end else begin
               half_d = half_q - 8'd1;
            end
         end
         PULSE_LO: begin
            if (half_q == 8'h00) begin
               if (cnt_q == 9'd1) begin
                  state_d = RESP;
               end else begin
                  cnt_d      = cnt_q - 9'd1;
                  half_d     = HALF_RELOAD;
                  csoc_clk_d = 1'b1;
                  state_d    = PULSE_HI;
               end
            end else begin
               half_d = half_q - 8'd1;
            end
         end
         RESP: if (uart.tx_ready_i) begin
            tx_data_d  = byte_idx_q ? EOL : (err_q ? 8'h3F : 8'h4B);
            tx_start_d = 1'b1;
            state_d    = RESP_WAIT;
         end
         RESP_WAIT: if (!uart.tx_ready_i) begin
            if (byte_idx_q) begin
               byte_idx_d = 1'b0;
               err_d      = 1'b0;
               state_d    = IDLE;
            end else begin
               byte_idx_d = 1'b1;
               state_d    = RESP;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == EXEC) || (state_d == PULSE_HI) || (state_d == PULSE_LO) ||
               (state_d == RESP) || (state_d == RESP_WAIT);
   end

   // State and output registers; reset aborts any pulse in progress
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cmd_q       <= 8'h00;
         arg_q       <= 8'h00;
         err_q       <= 1'b0;
         cnt_q       <= 9'd0;
         half_q      <= 8'h00;
         byte_idx_q  <= 1'b0;
         busy_q      <= 1'b0;
         csoc_clk_q  <= 1'b0;
         csoc_rstn_q <= 1'b0;
         se_q        <= 1'b0;
         tm_q        <= 1'b0;
         read_q      <= 1'b0;
         data_q      <= 8'h00;
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         arg_q       <= arg_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         half_q      <= half_d;
         byte_idx_q  <= byte_idx_d;
         busy_q      <= busy_d;
         csoc_clk_q  <= csoc_clk_d;
         csoc_rstn_q <= csoc_rstn_d;
         se_q        <= se_d;
         tm_q        <= tm_d;
         read_q      <= read_d;
         data_q      <= data_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
      end
   end

   assign csoc_clk        = csoc_clk_q;
   assign csoc_rstn       = csoc_rstn_q;
   assign csoc_test_se    = se_q;
   assign csoc_test_tm    = tm_q;
   assign csoc_uart_read  = read_q;
   assign csoc_data_o     = data_q;
   assign busy_o          = busy_q;
   assign uart.tx_data_o  = tx_data_q;
   assign uart.tx_start_o = tx_start_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with a simple transmitter model and csoc_clk monitor.
module tb_uart_cmd_decoder;
   logic       clk;
   logic       rstn;
   logic       csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_uart_read, busy_o;
   logic [7:0] csoc_data_o;

   uart_cmd_decoder_if u_if ();

   uart_cmd_decoder #(.CLK_HALF(4), .EOL(8'h0A)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .uart           (u_if.slave),
      .csoc_clk       (csoc_clk),
      .csoc_rstn      (csoc_rstn),
      .csoc_test_se   (csoc_test_se),
      .csoc_test_tm   (csoc_test_tm),
      .csoc_uart_read (csoc_uart_read),
      .csoc_data_o    (csoc_data_o),
      .busy_o         (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] txq[$];
   int   tx_busy_cnt = 0;
   logic tx_block    = 1'b0;

   int   cyc = 0, rises = 0, bad_hi = 0, bad_lo = 0, hi_run = 0, lo_run = 0;
   int   last_fall = 0, start_cyc = 0, reads = 0;
   logic got_start = 1'b0, prev_clk = 1'b0;
   logic [7:0] read_data = 8'h00;

   // Transmitter model plus output monitor, all sampled on the falling edge
   initial begin
      u_if.tx_ready_i = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (u_if.tx_start_o) begin
            txq.push_back(u_if.tx_data_o);
            tx_busy_cnt = 3;
            if (!got_start) begin
               got_start = 1'b1;
               start_cyc = cyc;
            end
         end else if (tx_busy_cnt > 0) begin
            tx_busy_cnt--;
         end
         u_if.tx_ready_i = (tx_busy_cnt == 0) && !tx_block;
         if (csoc_clk) begin
            if (!prev_clk) begin
               rises++;
               if (rises > 1 && lo_run != 4) bad_lo++;
               hi_run = 0;
            end
            hi_run++;
         end else begin
            if (prev_clk) begin
               if (hi_run != 4) bad_hi++;
               lo_run    = 0;
               last_fall = cyc;
            end
            lo_run++;
         end
         prev_clk = csoc_clk;
         if (csoc_uart_read) begin
            reads++;
            read_data = csoc_data_o;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      rises = 0; bad_hi = 0; bad_lo = 0; reads = 0; got_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      u_if.rx_data     = b;
      u_if.new_rx_data = 1'b1;
      @(negedge clk);
      u_if.new_rx_data = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_resp(input string tag, input logic [7:0] exp0);
      int n;
      n = 0;
      while (txq.size() < 1 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " busy_mid"}, {31'd0, busy_o}, 32'd1);
      while (txq.size() < 2 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " resp_count"}, txq.size(), 32'd2);
      if (txq.size() >= 2) begin
         check({tag, " byte0"}, {24'd0, txq[0]}, {24'd0, exp0});
         check({tag, " byte1"}, {24'd0, txq[1]}, 32'h0A);
         void'(txq.pop_front());
         void'(txq.pop_front());
      end
      repeat (2) @(negedge clk);
      check({tag, " busy_end"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      int n;
      rstn             = 1'b0;
      u_if.rx_data     = 8'h00;
      u_if.new_rx_data = 1'b0;
      repeat (3) @(negedge clk);
      check("rst csoc_rstn", {31'd0, csoc_rstn}, 32'd0);
      check("rst outs", {26'd0, csoc_clk, csoc_test_se, csoc_test_tm, csoc_uart_read,
                         u_if.tx_start_o, busy_o}, 32'd0);
      check("rst data", {16'd0, csoc_data_o, u_if.tx_data_o}, 32'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // release CSoC reset
      clear_mon();
      send_str("r\n");
      wait_resp("r", 8'h4B);
      check("r csoc_rstn", {31'd0, csoc_rstn}, 32'd1);
      check("r others", {28'd0, csoc_test_se, csoc_test_tm, csoc_uart_read, csoc_clk}, 32'd0);
      check("r rises", rises, 32'd0);

      // three stepped pulses
      clear_mon();
      send_str("C03\n");
      wait_resp("C03", 8'h4B);
      check("C03 rises", rises, 32'd3);
      check("C03 hi_len", bad_hi, 32'd0);
      check("C03 lo_len", bad_lo, 32'd0);
      check("C03 start_gap", start_cyc - last_fall, 32'd5);
      check("C03 clk_low", {31'd0, csoc_clk}, 32'd0);

      // 00 means 256 pulses
      clear_mon();
      send_str("C00\n");
      wait_resp("C00", 8'h4B);
      check("C00 rises", rises, 32'd256);
      check("C00 hi_len", bad_hi, 32'd0);

      // data write
      clear_mon();
      send_str("W5a\n");
      wait_resp("W5a", 8'h4B);
      check("W reads", reads, 32'd1);
      check("W read_data", {24'd0, read_data}, 32'h5A);
      check("W data_o", {24'd0, csoc_data_o}, 32'h5A);

      // malformed lines
      clear_mon();
      send_str("X\n");
      wait_resp("X", 8'h3F);
      send_str("CZ1\n");
      wait_resp("CZ1", 8'h3F);
      send_str("C1\n");
      wait_resp("C1", 8'h3F);
      send_str("Sx\n");
      wait_resp("Sx", 8'h3F);
      check("err rises", rises, 32'd0);
      check("err reads", reads, 32'd0);
      check("err levels", {29'd0, csoc_rstn, csoc_test_se, csoc_test_tm}, 32'b100);
      send_str("T\n");
      wait_resp("T", 8'h4B);
      check("T tm", {31'd0, csoc_test_tm}, 32'd1);

      // CR ignored
      send_str("S\n");
      wait_resp("S", 8'h4B);
      check("S se", {31'd0, csoc_test_se}, 32'd1);
      send_str("s\r\n");
      wait_resp("s_cr", 8'h4B);
      check("s se", {31'd0, csoc_test_se}, 32'd0);

      // bytes during pulsing are dropped
      clear_mon();
      send_str("C02\n");
      repeat (3) @(negedge clk);
      send_str("t\n");
      wait_resp("C02", 8'h4B);
      repeat (20) @(negedge clk);
      check("drop extra_resp", txq.size(), 32'd0);
      check("drop tm", {31'd0, csoc_test_tm}, 32'd1);
      check("drop rises", rises, 32'd2);

      // transmitter stalled: busy holds, bytes dropped
      tx_block = 1'b1;
      send_str("R\n");
      repeat (30) @(negedge clk);
      check("stall busy", {31'd0, busy_o}, 32'd1);
      check("stall no_tx", txq.size(), 32'd0);
      send_str("S\n");
      tx_block = 1'b0;
      wait_resp("stall", 8'h4B);
      check("stall csoc_rstn", {31'd0, csoc_rstn}, 32'd0);
      check("stall se", {31'd0, csoc_test_se}, 32'd0);
      repeat (20) @(negedge clk);
      check("stall extra_resp", txq.size(), 32'd0);

      // reset in the middle of a pulse
      send_str("C10\n");
      n = 0;
      while (!csoc_clk && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("midrst clk_seen", {31'd0, csoc_clk}, 32'd1);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst outs", {25'd0, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm,
                            csoc_uart_read, u_if.tx_start_o, busy_o}, 32'd0);
      repeat (2) @(negedge clk);
      txq.delete();
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      send_str("r\n");
      wait_resp("post_rst", 8'h4B);
      check("post_rst csoc_rstn", {31'd0, csoc_rstn}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
